ysyx_24100029_gshare_bpu: RTL and testbench

Parametrised next-generation branch predictor for the IFU: gshare direction prediction from a speculative global history register, a tagged direct-mapped BTB that also stores branch type, and an optional return address stack. The block produces a predicted npc for every fetch PC in the same cycle. It is trained from the commit stage, and it repairs its history on a mispredict.

---
 rtl/ysyx_24100029_gshare_bpu.sv | 173 +++++++++++++++++
 tb/tb_ysyx_24100029_gshare_bpu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_gshare_bpu.sv
// Gshare branch predictor: speculative GHR + 2-bit PHT, tagged direct-mapped BTB, optional RAS.
// Define YSYX_24100029_RAS_EN to build the return address stack; otherwise ret hits use the BTB target.
module ysyx_24100029_gshare_bpu #(
    parameter int GHR_W     = 4,
    parameter int PHT_IDX_W = 6,
    parameter int BTB_IDX_W = 3,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              fetch_valid,
    output logic [31:0]       npc,
    output logic              pred_taken,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              br_is_taken,
    input  logic [31:0]       br_pc,
    input  logic [31:0]       br_npc,
    input  logic [GHR_W-1:0]  br_ghr,
    input  logic              br_mispredict
);
    // fetch_valid qualifies pc and br_valid qualifies every br_* field; there is no
    // backpressure, so each is consumed in the cycle it is high.
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    typedef enum logic [1:0] {BR_COND = 2'b00, BR_JUMP = 2'b01, BR_CALL = 2'b10, BR_RET = 2'b11} br_type_e;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic [31:0]      tgt;
        br_type_e         typ;
    } btb_entry_t;

    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic [1:0]           pht_q [PHT_N];
    logic [1:0]           pht_d [PHT_N];
    btb_entry_t           btb_q [BTB_N];
    btb_entry_t           btb_d [BTB_N];

    logic [PHT_IDX_W-1:0] pht_ridx, pht_widx;
    logic [BTB_IDX_W-1:0] btb_ridx, btb_widx;
    btb_entry_t           rd_e;
    logic                 hit;
    logic [31:0]          pc_plus4;
    logic                 ras_valid;
    logic [31:0]          ras_top;
    logic                 unused_bits;

    assign pc_plus4    = pc + 32'd4;
    assign pht_ridx    = pc[2 +: PHT_IDX_W] ^ PHT_IDX_W'(ghr_q);
    assign pht_widx    = br_pc[2 +: PHT_IDX_W] ^ PHT_IDX_W'(br_ghr);
    assign btb_ridx    = pc[2 +: BTB_IDX_W];
    assign btb_widx    = br_pc[2 +: BTB_IDX_W];
    assign rd_e        = btb_q[btb_ridx];
    assign hit         = rd_e.v && (rd_e.tag == pc[31:2+BTB_IDX_W]);
    assign pred_ghr    = ghr_q;
    assign unused_bits = ^{pc[1:0], br_pc[1:0]};

    always_comb begin
        npc        = pc_plus4;
        pred_taken = 1'b0;
        if (hit) begin
            case (rd_e.typ)
                BR_COND: begin
                    if (pht_q[pht_ridx][1]) begin
                        pred_taken = 1'b1;
                        npc        = rd_e.tgt;
                    end
                end
                BR_RET: begin
                    pred_taken = 1'b1;
                    npc        = ras_valid ? ras_top : rd_e.tgt;
                end
                default: begin
                    pred_taken = 1'b1;
                    npc        = rd_e.tgt;
                end
            endcase
        end
    end

    // Commit-side repair wins over the speculative shift from the same cycle's fetch.
    always_comb begin
        ghr_d = ghr_q;
        pht_d = pht_q;
        btb_d = btb_q;
        if (br_valid && br_mispredict) begin
            if (br_type == BR_COND) ghr_d = {br_ghr[GHR_W-2:0], br_is_taken};
            else                    ghr_d = br_ghr;
        end else if (fetch_valid && hit && rd_e.typ == BR_COND) begin
            ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
        end
        if (br_valid && br_type == BR_COND) begin
            if (br_is_taken && pht_q[pht_widx] != 2'b11)
                pht_d[pht_widx] = pht_q[pht_widx] + 2'd1;
            else if (!br_is_taken && pht_q[pht_widx] != 2'b00)
                pht_d[pht_widx] = pht_q[pht_widx] - 2'd1;
        end
        if (br_valid && br_is_taken) begin
            btb_d[btb_widx].v   = 1'b1;
            btb_d[btb_widx].tag = br_pc[31:2+BTB_IDX_W];
            btb_d[btb_widx].tgt = br_npc;
            btb_d[btb_widx].typ = br_type_e'(br_type);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
            for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
        end else begin
            ghr_q <= ghr_d;
            pht_q <= pht_d;
            btb_q <= btb_d;
        end
    end

`ifdef YSYX_24100029_RAS_EN
    localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]          ras_q [RAS_DEPTH];
    logic [31:0]          ras_d [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d, ras_top_idx;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic                 ras_push, ras_pop;

    assign ras_top_idx = ras_ptr_q - RAS_PTR_W'(1);
    assign ras_valid   = (ras_cnt_q != '0);
    assign ras_top     = ras_q[ras_top_idx];
    assign ras_push    = fetch_valid && hit && rd_e.typ == BR_CALL;
    assign ras_pop     = fetch_valid && hit && rd_e.typ == BR_RET;

    // Circular storage: pushing when full silently drops the oldest return address.
    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push) begin
            ras_d[ras_ptr_q] = pc_plus4;
            ras_ptr_d        = ras_ptr_q + RAS_PTR_W'(1);
            if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
        end else if (ras_pop && ras_valid) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_q     <= ras_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = (RAS_DEPTH > 0);
    assign ras_valid  = 1'b0;
    assign ras_top    = '0;
`endif

endmodule

// File: tb/tb_ysyx_24100029_gshare_bpu.sv
// Directed bench for the gshare predictor: driver pushes expected {npc, taken, ghr} per probe,
// a negedge monitor pops and compares while the probe strobe is high.
module tb_ysyx_24100029_gshare_bpu;
    localparam int GHR_W     = 4;
    localparam int PHT_IDX_W = 6;
    localparam int BTB_IDX_W = 4;
    localparam int RAS_DEPTH = 4;
    localparam int EW        = 32 + 1 + GHR_W;

    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_JUMP = 2'b01;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;

`ifdef YSYX_24100029_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic [31:0]       pc;
    logic              fetch_valid;
    logic [31:0]       npc;
    logic              pred_taken;
    logic [GHR_W-1:0]  pred_ghr;
    logic              br_valid;
    logic [1:0]        br_type;
    logic              br_is_taken;
    logic [31:0]       br_pc;
    logic [31:0]       br_npc;
    logic [GHR_W-1:0]  br_ghr;
    logic              br_mispredict;

    logic              probe_v;
    logic [EW-1:0]     exp_q[$];
    string             name_q[$];
    logic [EW-1:0]     exp_item;
    logic [EW-1:0]     act_item;
    string             nm;
    int                n_vec;
    int                n_miss;

    ysyx_24100029_gshare_bpu #(
        .GHR_W(GHR_W), .PHT_IDX_W(PHT_IDX_W), .BTB_IDX_W(BTB_IDX_W), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .pc(pc), .fetch_valid(fetch_valid),
        .npc(npc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .br_valid(br_valid), .br_type(br_type), .br_is_taken(br_is_taken),
        .br_pc(br_pc), .br_npc(br_npc), .br_ghr(br_ghr), .br_mispredict(br_mispredict)
    );

    // Clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (probe_v) begin
            if (exp_q.size() == 0) begin
                $display("FAIL no_expect: probe strobe with empty expected queue");
                n_miss++;
            end else begin
                exp_item = exp_q.pop_front();
                nm       = name_q.pop_front();
                act_item = {npc, pred_taken, pred_ghr};
                if (act_item !== exp_item) begin
                    $display("FAIL %s: got npc=%h taken=%b ghr=%b, expected npc=%h taken=%b ghr=%b",
                             nm, act_item[EW-1 -: 32], act_item[GHR_W], act_item[GHR_W-1:0],
                             exp_item[EW-1 -: 32], exp_item[GHR_W], exp_item[GHR_W-1:0]);
                    n_miss++;
                end
            end
        end
    end

    // Driver tasks
    task automatic set_commit(input logic [1:0] t, input logic tk, input logic [31:0] bpc,
                              input logic [31:0] bnpc, input logic [GHR_W-1:0] g, input logic mp);
        br_valid      = 1'b1;
        br_type       = t;
        br_is_taken   = tk;
        br_pc         = bpc;
        br_npc        = bnpc;
        br_ghr        = g;
        br_mispredict = mp;
    endtask

    task automatic clear_commit();
        br_valid      = 1'b0;
        br_mispredict = 1'b0;
    endtask

    task automatic commit(input logic [1:0] t, input logic tk, input logic [31:0] bpc,
                          input logic [31:0] bnpc, input logic [GHR_W-1:0] g, input logic mp);
        set_commit(t, tk, bpc, bnpc, g, mp);
        @(posedge clock);
        #1;
        clear_commit();
    endtask

    task automatic probe(input string name, input logic [31:0] p, input logic fv,
                         input logic [31:0] e_npc, input logic e_tk, input logic [GHR_W-1:0] e_ghr);
        pc          = p;
        fetch_valid = fv;
        exp_q.push_back({e_npc, e_tk, e_ghr});
        name_q.push_back(name);
        n_vec++;
        probe_v = 1'b1;
        @(posedge clock);
        #1;
        probe_v     = 1'b0;
        fetch_valid = 1'b0;
        clear_commit();
    endtask

    // Directed stimulus
    initial begin
        n_vec = 0; n_miss = 0; probe_v = 1'b0;
        reset = 1'b0; pc = 32'h8000_0000; fetch_valid = 1'b0;
        br_valid = 1'b0; br_type = T_COND; br_is_taken = 1'b0;
        br_pc = '0; br_npc = '0; br_ghr = '0; br_mispredict = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        probe("rst_out", 32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b0000);
        reset = 1'b1;
        probe("idle_miss", 32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b0000);

        // Conditional training and saturation at index 4
        repeat (3) commit(T_COND, 1'b1, 32'h8000_0010, 32'h8000_0100, 4'b0000, 1'b0);
        probe("cond_taken", 32'h8000_0010, 1'b0, 32'h8000_0100, 1'b1, 4'b0000);
        probe("tag_miss",   32'h8000_0050, 1'b0, 32'h8000_0054, 1'b0, 4'b0000);
        commit(T_COND, 1'b0, 32'h8000_0010, 32'h8000_0100, 4'b0000, 1'b0);
        probe("ctr2_taken", 32'h8000_0010, 1'b0, 32'h8000_0100, 1'b1, 4'b0000);
        repeat (4) commit(T_COND, 1'b0, 32'h8000_0010, 32'h8000_0100, 4'b0000, 1'b0);
        commit(T_COND, 1'b1, 32'h8000_0010, 32'h8000_0100, 4'b0000, 1'b0);
        probe("ctr_sat_low", 32'h8000_0010, 1'b0, 32'h8000_0014, 1'b0, 4'b0000);

        // BTB read-during-write returns the old entry
        set_commit(T_JUMP, 1'b1, 32'h8000_0048, 32'h8000_0700, 4'b0000, 1'b0);
        probe("btb_rdw_old", 32'h8000_0048, 1'b0, 32'h8000_004C, 1'b0, 4'b0000);
        probe("btb_new",     32'h8000_0048, 1'b0, 32'h8000_0700, 1'b1, 4'b0000);

        // Call / ret
        commit(T_CALL, 1'b1, 32'h8000_0020, 32'h8000_0400, 4'b0000, 1'b0);
        commit(T_RET,  1'b1, 32'h8000_0200, 32'h8000_0900, 4'b0000, 1'b0);
        probe("call",      32'h8000_0020, 1'b1, 32'h8000_0400, 1'b1, 4'b0000);
        probe("ret_ras",   32'h8000_0200, 1'b1, RAS_ON ? 32'h8000_0024 : 32'h8000_0900, 1'b1, 4'b0000);
        probe("ret_empty", 32'h8000_0200, 1'b0, 32'h8000_0900, 1'b1, 4'b0000);

        // RAS overflow: calls A..E then five rets
        for (int i = 1; i < 5; i++)
            commit(T_CALL, 1'b1, 32'h8000_0020 + 32'(4*i), 32'h8000_0400 + 32'(16*i), 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++)
            probe($sformatf("ovf_call%0d", i), 32'h8000_0020 + 32'(4*i), 1'b1,
                  32'h8000_0400 + 32'(16*i), 1'b1, 4'b0000);
        for (int j = 0; j < 5; j++)
            probe($sformatf("ovf_ret%0d", j), 32'h8000_0200, 1'b1,
                  (RAS_ON && j < 4) ? (32'h8000_0034 - 32'(4*j)) : 32'h8000_0900, 1'b1, 4'b0000);

        // Speculative history shifts
        commit(T_JUMP, 1'b1, 32'h8000_0044, 32'h8000_0800, 4'b1011, 1'b1);
        probe("ghr_set",  32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b1011);
        probe("shift_nt", 32'h8000_0010, 1'b1, 32'h8000_0014, 1'b0, 4'b1011);
        probe("after_nt", 32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b0110);
        repeat (2) commit(T_COND, 1'b1, 32'h8000_0010, 32'h8000_0100, 4'b0110, 1'b0);
        probe("shift_t",  32'h8000_0010, 1'b1, 32'h8000_0100, 1'b1, 4'b0110);
        probe("after_t",  32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b1101);

        // Repair beats a same-cycle predicted-cond fetch
        commit(T_JUMP, 1'b1, 32'h8000_0044, 32'h8000_0800, 4'b1011, 1'b1);
        set_commit(T_COND, 1'b1, 32'h8000_0018, 32'h8000_0500, 4'b0101, 1'b1);
        probe("repair_fetch", 32'h8000_0010, 1'b1, 32'h8000_0014, 1'b0, 4'b1011);
        probe("repair_res",   32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b1011);
        set_commit(T_COND, 1'b0, 32'h8000_0018, 32'h8000_0500, 4'b0010, 1'b1);
        probe("repair2_fetch", 32'h8000_0010, 1'b1, 32'h8000_0014, 1'b0, 4'b1011);
        probe("repair2_res",   32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0, 4'b0100);

        // Asynchronous reset mid-operation
        reset = 1'b0;
        probe("rst_mid", 32'h8000_0010, 1'b0, 32'h8000_0014, 1'b0, 4'b0000);
        reset = 1'b1;
        probe("post_rst", 32'h8000_0010, 1'b0, 32'h8000_0014, 1'b0, 4'b0000);

        @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
